// File: rtl/fios_operand_server.sv
// -----------------------------------------------------------------------------
// fios_operand_server
//
// Memory-side responder for the FIOS Montgomery cascade. It holds the
// multi-word operand B and the modulus P and serves one W-bit word of each per
// fetch request. It also collects the result words pushed out of the last PE,
// assembles them into a full-width result and hands that result to the system
// over a valid/ready handshake.
//
// Ports
//   clock_i          system clock
//   reset_n_i        asynchronous active-low reset
//   load_i           strobe: capture B_i/P_i and restart the block
//   B_i, P_i         operands, word k at bits [k*W +: W]
//   b_fetch_i        advance the B read pointer (wraps after word S-1)
//   p_fetch_i        advance the P read pointer (wraps after word S-1)
//   rewind_i         strobe: both read pointers back to word 0
//   b_word_o         registered current B word
//   p_word_o         registered current P word
//   RES_push_i       result word strobe, least significant word first
//   RES_word_i       result word
//   result_o         assembled result, frozen while result_valid_o is high
//   result_valid_o   full result available
//   result_ready_i   consumer accepts the result
//   overflow_o       sticky: a push was dropped while a result was held
//
// Result assembly states
//   state       | meaning
//   ST_COLLECT  | accepting pushes into result word wr_idx
//   ST_HOLD     | full result presented, waiting for result_ready_i
//
// Precedence each cycle: load_i > rewind_i > fetch.
// -----------------------------------------------------------------------------
module fios_operand_server #(
    parameter int S = 16,
    parameter int W = 17
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           load_i,
    input  logic [S*W-1:0] B_i,
    input  logic [S*W-1:0] P_i,
    input  logic           b_fetch_i,
    input  logic           p_fetch_i,
    input  logic           rewind_i,
    output logic [W-1:0]   b_word_o,
    output logic [W-1:0]   p_word_o,
    input  logic           RES_push_i,
    input  logic [W-1:0]   RES_word_i,
    output logic [S*W-1:0] result_o,
    output logic           result_valid_o,
    input  logic           result_ready_i,
    output logic           overflow_o
);

    localparam int PW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    logic [S*W-1:0] b_mem_q;
    logic [S*W-1:0] p_mem_q;
    logic [PW-1:0]  b_ptr_q;
    logic [PW-1:0]  p_ptr_q;
    logic [PW-1:0]  b_ptr_d;
    logic [PW-1:0]  p_ptr_d;
    logic [W-1:0]   b_word_q;
    logic [W-1:0]   p_word_q;

    state_t         state_q;
    logic [PW-1:0]  wr_idx_q;
    logic [S*W-1:0] result_q;
    logic           valid_q;
    logic           overflow_q;

    // Incremented read pointers with wrap after the last word.
    always_comb begin
        b_ptr_d = (b_ptr_q == PW'(S - 1)) ? '0 : b_ptr_q + PW'(1);
        p_ptr_d = (p_ptr_q == PW'(S - 1)) ? '0 : p_ptr_q + PW'(1);
    end

    // Operand storage and word serving. The output word is registered
    // together with the pointer, so it always shows the word at the pointer.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            b_mem_q  <= '0;
            p_mem_q  <= '0;
            b_ptr_q  <= '0;
            p_ptr_q  <= '0;
            b_word_q <= '0;
            p_word_q <= '0;
        end else if (load_i) begin
            b_mem_q  <= B_i;
            p_mem_q  <= P_i;
            b_ptr_q  <= '0;
            p_ptr_q  <= '0;
            b_word_q <= B_i[W-1:0];
            p_word_q <= P_i[W-1:0];
        end else if (rewind_i) begin
            b_ptr_q  <= '0;
            p_ptr_q  <= '0;
            b_word_q <= b_mem_q[W-1:0];
            p_word_q <= p_mem_q[W-1:0];
        end else begin
            if (b_fetch_i) begin
                b_ptr_q  <= b_ptr_d;
                b_word_q <= b_mem_q[int'(b_ptr_d)*W +: W];
            end
            if (p_fetch_i) begin
                p_ptr_q  <= p_ptr_d;
                p_word_q <= p_mem_q[int'(p_ptr_d)*W +: W];
            end
        end
    end

    // Result assembly FSM with registered valid/overflow.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_COLLECT;
            wr_idx_q   <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (load_i) begin
            // Load discards any partial or held result.
            state_q    <= ST_COLLECT;
            wr_idx_q   <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (RES_push_i) begin
                        result_q[int'(wr_idx_q)*W +: W] <= RES_word_i;
                        if (wr_idx_q == PW'(S - 1)) begin
                            wr_idx_q <= '0;
                            valid_q  <= 1'b1;
                            state_q  <= ST_HOLD;
                        end else begin
                            wr_idx_q <= wr_idx_q + PW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (result_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= ST_COLLECT;
                        // A push coinciding with the handshake starts the
                        // next result rather than being lost.
                        if (RES_push_i) begin
                            result_q[W-1:0] <= RES_word_i;
                            wr_idx_q        <= PW'(1);
                        end
                    end else if (RES_push_i) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_COLLECT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign b_word_o       = b_word_q;
    assign p_word_o       = p_word_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign overflow_o     = overflow_q;

endmodule
